// File: rtl/iir_pkg.sv
// Shared types, widths, coefficients and fixed-point helpers for the de-emphasis filter.
package iir_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned QUANT_BITS = 10;
  localparam int unsigned Q_BIAS     = (1 << QUANT_BITS) - 1;

  // W_PP = 0.21140067: X = trunc(1024*W/(1+W)), Y1 = trunc(1024*(W-1)/(W+1))
  localparam logic signed [DATA_WIDTH-1:0] X0 = 32'sd178;
  localparam logic signed [DATA_WIDTH-1:0] X1 = 32'sd178;
  localparam logic signed [DATA_WIDTH-1:0] Y1 = -32'sd666;

  typedef enum logic {
    S_READ = 1'b0,
    S_CALC = 1'b1
  } state_e;

  // Full-precision signed product of a sample and a coefficient.
  function automatic logic signed [PROD_WIDTH-1:0] mulq(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return PROD_WIDTH'(a) * PROD_WIDTH'(b);
  endfunction

  // Divide by 2^QUANT_BITS truncating toward zero, keep the low DATA_WIDTH bits.
  function automatic logic signed [DATA_WIDTH-1:0] deq(
    input logic signed [PROD_WIDTH-1:0] p
  );
    logic signed [PROD_WIDTH-1:0] biased;
    logic signed [PROD_WIDTH-1:0] shifted;
    biased = p;
    if (p[PROD_WIDTH-1]) begin
      biased = p + PROD_WIDTH'(Q_BIAS);
    end
    shifted = biased >>> QUANT_BITS;
    return shifted[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO; head is presented on dout whenever not empty.
module fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_c, pop_c;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Accept writes only with room, reads only with data; both may occur together.
  always_comb begin
    push_c   = wr_en && !full;
    pop_c    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/iir_deemph_top.sv
// FM de-emphasis: first-order IIR low-pass between an input and an output FIFO.
module iir_deemph_top
  import iir_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_wr_en,
  output logic                  in_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_rd_en,
  output logic                  out_empty
);

  logic [DATA_WIDTH-1:0]        in_dout;
  logic                         in_empty;
  logic                         in_rd_en_c;
  logic                         out_full;
  logic                         out_wr_en_c;
  logic [DATA_WIDTH-1:0]        out_din_c;

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] xn_q, xn_d;
  logic signed [DATA_WIDTH-1:0] x1_q, x1_d;
  logic signed [DATA_WIDTH-1:0] y1_q, y1_d;
  logic signed [DATA_WIDTH-1:0] y_new_c;

  fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .din   (din),
    .wr_en (in_wr_en),
    .full  (in_full),
    .dout  (in_dout),
    .rd_en (in_rd_en_c),
    .empty (in_empty)
  );

  fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .din   (out_din_c),
    .wr_en (out_wr_en_c),
    .full  (out_full),
    .dout  (dout),
    .rd_en (out_rd_en),
    .empty (out_empty)
  );

  // Filter datapath: y[n] from the latched x[n] and the stored history; sums wrap.
  always_comb begin
    y_new_c = deq(mulq(xn_q, X0)) + deq(mulq(x1_q, X1)) + deq(mulq(y1_q, Y1));
  end

  // Core FSM: fetch a sample only when the result is guaranteed a slot downstream.
  always_comb begin
    state_d     = state_q;
    xn_d        = xn_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    in_rd_en_c  = 1'b0;
    out_wr_en_c = 1'b0;
    out_din_c   = y1_q;
    case (state_q)
      S_READ: begin
        if (!in_empty && !out_full) begin
          in_rd_en_c = 1'b1;
          xn_d       = in_dout;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        out_wr_en_c = 1'b1;
        x1_d        = xn_q;
        y1_d        = y_new_c;
        state_d     = S_READ;
      end
      default: state_d = S_READ;
    endcase
  end

  // State and filter history registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_READ;
      xn_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      state_q <= state_d;
      xn_q    <= xn_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
    end
  end

endmodule

// File: tb/tb_iir_deemph_top.sv
// Scoreboard bench for iir_deemph_top: random and directed samples vs. a plain-arithmetic model.
module tb_iir_deemph_top;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clock;
  logic          reset;
  logic [DW-1:0] din;
  logic          in_wr_en;
  logic          in_full;
  logic [DW-1:0] dout;
  logic          out_rd_en;
  logic          out_empty;

  iir_deemph_top #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .in_wr_en  (in_wr_en),
    .in_full   (in_full),
    .dout      (dout),
    .out_rd_en (out_rd_en),
    .out_empty (out_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int rd_mode = 0;            // 0: never read, 1: random reads, 2: always read
  logic [DW-1:0] sb[$];       // expected outputs in order
  logic [DW-1:0] log_q[$];    // observed outputs of the current test
  logic [DW-1:0] stim_q[$];   // samples waiting to be written
  int xp_m, yp_m;             // model history x[n-1], y[n-1]

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Divide by 1024 truncating toward zero (SV integer division does exactly that).
  function automatic int deq_m(input longint p);
    return int'(p / 64'sd1024);
  endfunction

  // Reference recurrence: emit y[n-1], then advance to y[n].
  task automatic model_push(input logic [DW-1:0] x);
    int xi;
    longint s;
    xi = x;
    sb.push_back(DW'(yp_m));
    s = longint'(deq_m(longint'(xi) * 178)) + longint'(deq_m(longint'(xp_m) * 178))
      + longint'(deq_m(longint'(yp_m) * -666));
    xp_m = xi;
    yp_m = int'(s);
  endtask

  task automatic model_reset();
    xp_m = 0;
    yp_m = 0;
    sb.delete();
    log_q.delete();
  endtask

  // Reader: chooses out_rd_en each cycle according to rd_mode.
  always @(negedge clock) begin
    case (rd_mode)
      2:       out_rd_en = 1'b1;
      1:       out_rd_en = ($urandom_range(0, 3) != 0);
      default: out_rd_en = 1'b0;
    endcase
  end

  // Monitor: a pop happens on the next edge, so the current head is what leaves.
  always @(negedge clock) begin
    #1;
    if (reset && out_rd_en && !out_empty) begin
      log_q.push_back(dout);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=0x%08h required=none", dout);
      end else begin
        check("dout", dout, sb.pop_front());
      end
    end
  end

  // Write every queued sample as fast as in_full allows; while full, offer junk that must be ignored.
  task automatic send_all(input bit gaps);
    int cyc;
    cyc = 0;
    while (stim_q.size() != 0) begin
      @(negedge clock);
      cyc++;
      if (cyc > 5000) begin
        fail_bound("send_all");
        stim_q.delete();
        break;
      end
      if (in_full) begin
        din      = $urandom;
        in_wr_en = 1'b1;
      end else if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_wr_en = 1'b0;
      end else begin
        din      = stim_q.pop_front();
        in_wr_en = 1'b1;
        model_push(din);
      end
    end
    @(negedge clock);
    in_wr_en = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    if (sb.size() != 0) fail_bound("drain");
    repeat (4) @(negedge clock);
    #2;
    check("drained_out_empty", DW'(out_empty), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rd_mode  = 0;
    in_wr_en = 1'b0;
    reset    = 1'b0;
    model_reset();
    @(negedge clock);
    #2;
    check("rst_out_empty", DW'(out_empty), 32'd1);
    check("rst_in_full", DW'(in_full), 32'd0);
    check("rst_dout", dout, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    log_q.delete();
  endtask

  task automatic check_log(input string name, input int idx, input logic [DW-1:0] exp);
    if (log_q.size() <= idx) begin
      fail_bound(name);
    end else begin
      check(name, log_q[idx], exp);
    end
  endtask

  task automatic run_impulse(input string name);
    stim_q.push_back(32'h0000_0400);
    repeat (5) stim_q.push_back(32'h0);
    rd_mode = 1;
    send_all(1'b0);
    drain();
    check_log({name, "_0"}, 0, 32'h0000_0000);
    check_log({name, "_1"}, 1, 32'h0000_00B2);
    check_log({name, "_2"}, 2, 32'h0000_003F);
    check_log({name, "_3"}, 3, 32'hFFFF_FFD8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    din       = '0;
    in_wr_en  = 1'b0;
    out_rd_en = 1'b0;
    model_reset();
    #12;
    check("init_out_empty", DW'(out_empty), 32'd1);
    check("init_in_full", DW'(in_full), 32'd0);
    check("init_dout", dout, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset while idle.
    do_reset();

    // Positive impulse.
    run_impulse("impulse");

    // Negative impulse: truncation toward zero keeps magnitudes symmetric.
    do_reset();
    stim_q.push_back(32'hFFFF_FC00);
    repeat (4) stim_q.push_back(32'h0);
    rd_mode = 1;
    send_all(1'b0);
    drain();
    check_log("neg_0", 0, 32'h0000_0000);
    check_log("neg_1", 1, 32'hFFFF_FF4E);
    check_log("neg_2", 2, 32'hFFFF_FFC1);

    // -1 alone: every partial product truncates to zero.
    do_reset();
    stim_q.push_back(32'hFFFF_FFFF);
    repeat (4) stim_q.push_back(32'h0);
    rd_mode = 1;
    send_all(1'b0);
    drain();
    for (int i = 0; i < 5; i++) check_log("minus1_zero", i, 32'h0);

    // Backpressure: no reads until both FIFOs are full.
    do_reset();
    for (int i = 0; i < 40; i++) stim_q.push_back($urandom);
    fork
      send_all(1'b0);
      begin
        repeat (100) @(negedge clock);
        #2;
        check("bp_in_full", DW'(in_full), 32'd1);
        check("bp_accepted", DW'(sb.size()), DW'(2 * DEPTH));
        rd_mode = 1;
      end
    join
    drain();
    check("bp_count", DW'(log_q.size()), 32'd40);

    // Continuous stream: mix of audio-range and full-range samples, reader always ready.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i % 4 == 3) stim_q.push_back($urandom);
      else stim_q.push_back(DW'(int'($urandom_range(0, 2_000_000)) - 1_000_000));
    end
    rd_mode = 2;
    send_all(1'b0);
    drain();
    check("stream_count", DW'(log_q.size()), 32'd100);

    // Random write gaps with random reads.
    for (int i = 0; i < 60; i++) stim_q.push_back($urandom);
    rd_mode = 1;
    send_all(1'b1);
    drain();

    // Reset mid-stream, then a fresh impulse must look like the first one.
    do_reset();
    for (int i = 0; i < 10; i++) stim_q.push_back($urandom);
    rd_mode = 1;
    send_all(1'b0);
    do_reset();
    run_impulse("post_reset_impulse");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
